// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and helpers for the unified memory-port arbiter.
//   arb_state_t : arbiter phase (IDLE, REQ = request on the memory bus,
//                 RESP = waiting for read data)
//   arb_owner_t : which requester owns the current transaction
//   cnt_width() : width of the timeout counter, never narrower than 1 bit
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_t;

    // Bits needed to hold the values 0..max_count (minimum 1).
    function automatic int cnt_width(input int max_count);
        int w;
        w = $clog2(max_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// -----------------------------------------------------------------------------
// mem_arb_if
// Bundles the fetch port, the load/store port and the memory-side port of the
// arbiter.
//   Parameters : ADDR_W (address width), DATA_W (data width, byte enables are
//                DATA_W/8 wide)
//   Fetch      : if_req, if_addr -> if_gnt, if_rvalid, if_rdata, if_err
//   Data       : d_req, d_we, d_addr, d_wdata, d_be -> d_gnt, d_rvalid,
//                d_rdata, d_err
//   Memory     : mem_req, mem_we, mem_addr, mem_wdata, mem_be ->
//                mem_ready, mem_rvalid, mem_rdata
//   Modports   : master = arbiter side, slave = core + memory side
// -----------------------------------------------------------------------------
interface mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // fetch port (read-only)
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    // load/store port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    // memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_ready, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output mem_ready, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational owner selection for the arbiter.
//   i_if_req     : fetch request pending
//   i_d_req      : data request pending
//   i_last_owner : owner of the most recent grant
//   o_owner      : selected owner (meaningful when o_any_req)
//   o_any_req    : at least one request pending
// A lone request is always served. On a conflict the requester that was NOT
// granted last wins; tying i_last_owner to OWN_FETCH turns this into a fixed
// data-over-fetch priority.
// -----------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_if_req,
    input  logic       i_d_req,
    input  arb_owner_t i_last_owner,
    output arb_owner_t o_owner,
    output logic       o_any_req
);

    always_comb begin
        o_any_req = i_if_req | i_d_req;
        o_owner   = OWN_FETCH;
        if (i_d_req && i_if_req) begin
            o_owner = (i_last_owner == OWN_DATA) ? OWN_FETCH : OWN_DATA;
        end else if (i_d_req) begin
            o_owner = OWN_DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one unified instruction/data memory port between the fetch stage and
// the load/store unit. One transaction outstanding at a time; a transaction
// that stays in REQ/RESP for TIMEOUT cycles is aborted with an err pulse.
//   Parameters : ADDR_W, DATA_W, TIMEOUT (0 disables the timeout)
//   Ports      : clk, rst (synchronous, active-high)
//                bus (mem_arb_if.master): fetch, load/store and memory ports
//   Build macro: MEM_ARB_RR_EN - when defined, conflicting requests alternate
//                (round-robin via a last-owner register); when undefined, data
//                always beats fetch and no last-owner register exists.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    mem_arb_if.master    bus
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    arb_owner_t        r_owner;
    arb_owner_t        w_pick_owner;
    arb_owner_t        w_last_owner;
    logic              w_any_req;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [BE_W-1:0]   r_mem_be;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_accept;
    logic              w_resp_done;
    logic              w_timeout;
    logic              w_load_latch;
    logic              w_cnt_expired;
    logic [BE_W-1:0]   w_be_pick;

`ifdef MEM_ARB_RR_EN
    arb_owner_t r_last_owner;

    // Starts as FETCH so that the first conflict goes to data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= OWN_FETCH;
        end else if (w_accept) begin
            r_last_owner <= r_owner;
        end
    end

    assign w_last_owner = r_last_owner;
`else
    // Constant FETCH makes the picker resolve every conflict to data.
    assign w_last_owner = OWN_FETCH;
`endif

    mem_arb_pick u_pick (
        .i_if_req     (bus.if_req),
        .i_d_req      (bus.d_req),
        .i_last_owner (w_last_owner),
        .o_owner      (w_pick_owner),
        .o_any_req    (w_any_req)
    );

    // Fetch transactions always read whole words.
    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_be_lane
            assign w_be_pick[gi] = (w_pick_owner == OWN_DATA) ? bus.d_be[gi] : 1'b1;
        end
    endgenerate

    // The counter saturates at TIMEOUT, so a load accepted on the very last
    // cycle still gets one RESP cycle to return data before it is aborted.
    assign w_cnt_expired = (TIMEOUT > 0) && (r_cnt == CNT_LIMIT);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_resp_done  = 1'b0;
        w_timeout    = 1'b0;
        w_load_latch = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_load_latch = 1'b1;
                    w_state_next = REQ;
                end
            end
            REQ: begin
                // Acceptance is checked first: completion beats timeout.
                if (bus.mem_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = r_mem_we ? IDLE : RESP;
                end else if (w_cnt_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            RESP: begin
                if (bus.mem_rvalid) begin
                    w_resp_done  = 1'b1;
                    w_state_next = IDLE;
                end else if (w_cnt_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= OWN_FETCH;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_cnt       <= '0;
        end else begin
            r_state   <= w_state_next;
            r_mem_req <= (w_state_next == REQ);
            if (w_load_latch) begin
                r_owner     <= w_pick_owner;
                r_mem_we    <= (w_pick_owner == OWN_DATA) && bus.d_we;
                r_mem_addr  <= (w_pick_owner == OWN_DATA) ? bus.d_addr : bus.if_addr;
                r_mem_wdata <= (w_pick_owner == OWN_DATA) ? bus.d_wdata : '0;
                r_mem_be    <= w_be_pick;
                r_cnt       <= '0;
            end else if ((r_state != IDLE) && (r_cnt != CNT_LIMIT)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Per-port pulses; forced low while reset is asserted so an in-flight
    // response arriving during reset is never forwarded.
    logic w_if_own, w_d_own, w_if_rvalid, w_d_rvalid;
    assign w_if_own    = !rst && (r_owner == OWN_FETCH);
    assign w_d_own     = !rst && (r_owner == OWN_DATA);
    assign w_if_rvalid = w_if_own && w_resp_done;
    assign w_d_rvalid  = w_d_own && w_resp_done;

    assign bus.if_gnt    = w_if_own && w_accept;
    assign bus.if_rvalid = w_if_rvalid;
    assign bus.if_rdata  = w_if_rvalid ? bus.mem_rdata : '0;
    assign bus.if_err    = w_if_own && w_timeout;

    assign bus.d_gnt     = w_d_own && w_accept;
    assign bus.d_rvalid  = w_d_rvalid;
    assign bus.d_rdata   = w_d_rvalid ? bus.mem_rdata : '0;
    assign bus.d_err     = w_d_own && w_timeout;

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;

endmodule
